// File: rtl/print_fmt_pkg.sv
// Shared types, constants and helpers for the debug-unit print formatter.
// Hex digits are produced arithmetically so no character ROM is needed.
package print_fmt_pkg;

  typedef enum logic [1:0] {
    MODE_RAW   = 2'd0,
    MODE_HEX   = 2'd1,
    MODE_HEXNL = 2'd2,
    MODE_HEXB  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Uppercase hex: '0'..'9' for 0..9, 'A'..'F' for 10..15.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // Total characters in one print; the byte-hex mode never carries separators.
  function automatic int char_count(input mode_e m, input int data_w, input int group);
    int n;
    int c;
    if (m == MODE_RAW) return 1;
    if (m == MODE_HEXB) return 2;
    n = data_w / 4;
    c = n;
    if (group != 0) c = c + (n - 1) / group;
    if (m == MODE_HEXNL) c = c + 2;
    return c;
  endfunction

endpackage

// File: rtl/print_fmt_req_edge_det.sv
// Asynchronous-reset rising-edge detector for level request lines.
// Shared by the debug-unit blocks that turn a held req into a single event.
module req_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic rise
);

  logic req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= req;
  end

  assign rise = req & ~req_q;

endmodule

// File: rtl/print_fmt.sv
// Print formatter: turns one captured value into an ASCII stream for the UART TX,
// as a raw byte, hex byte, or grouped hex word with optional CR/LF.
module print_fmt
  import print_fmt_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         GROUP    = 4,
  parameter logic [7:0] SEP_CHAR = 8'h5F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        mode,
  input  logic              req,
  input  logic              rdy_tx,
  output logic              vld_tx,
  output logic [7:0]        d_tx,
  output logic              ack,
  output logic              busy
);

  localparam int N         = DATA_W / 4;
  localparam int CNT_HEX   = char_count(MODE_HEX, DATA_W, GROUP);
  localparam int CNT_HEXNL = char_count(MODE_HEXNL, DATA_W, GROUP);
  localparam int CNT_HEXB  = char_count(MODE_HEXB, DATA_W, GROUP);
  localparam int CNT_RAW   = char_count(MODE_RAW, DATA_W, GROUP);
  localparam int CNT_W     = $clog2(CNT_HEXNL + 1);
  localparam int NIB_W     = $clog2(N + 1);

  state_e            state, state_n;
  mode_e             cur_mode, mode_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [NIB_W-1:0]  nib_done, nib_n;
  logic [NIB_W-1:0]  grp_cnt, grp_n;
  logic [CNT_W-1:0]  rem, rem_n;
  logic              vld_n, ack_n, busy_n;
  logic [7:0]        d_n;
  logic              rise, start;
  logic [NIB_W-1:0]  nib_total;
  logic              sep_ok;

  req_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .rise (rise)
  );

  assign start     = rise & (state == S_IDLE);
  assign nib_total = (cur_mode == MODE_HEXB) ? NIB_W'(2) : NIB_W'(N);
  assign sep_ok    = (GROUP != 0) && ((cur_mode == MODE_HEX) || (cur_mode == MODE_HEXNL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cur_mode <= MODE_RAW;
      sh       <= '0;
      nib_done <= '0;
      grp_cnt  <= '0;
      rem      <= '0;
      vld_tx   <= 1'b0;
      d_tx     <= 8'h00;
      ack      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_mode <= mode_n;
      sh       <= sh_n;
      nib_done <= nib_n;
      grp_cnt  <= grp_n;
      rem      <= rem_n;
      vld_tx   <= vld_n;
      d_tx     <= d_n;
      ack      <= ack_n;
      busy     <= busy_n;
    end
  end

  // rem counts characters still owed including the one on d_tx; the next
  // character is chosen at the moment the current one is accepted.
  always_comb begin
    state_n = state;
    mode_n  = cur_mode;
    sh_n    = sh;
    nib_n   = nib_done;
    grp_n   = grp_cnt;
    rem_n   = rem;
    vld_n   = vld_tx;
    d_n     = d_tx;
    ack_n   = 1'b0;
    busy_n  = busy;

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_n  = mode_e'(mode);
          vld_n   = 1'b1;
          busy_n  = 1'b1;
          state_n = S_EMIT;
          case (mode_e'(mode))
            MODE_RAW: begin
              d_n   = din[7:0];
              sh_n  = '0;
              nib_n = '0;
              grp_n = '0;
              rem_n = CNT_W'(CNT_RAW);
            end
            MODE_HEXB: begin
              d_n   = nib2ascii(din[7:4]);
              sh_n  = {din[3:0], {(DATA_W-4){1'b0}}};
              nib_n = NIB_W'(1);
              grp_n = NIB_W'(1);
              rem_n = CNT_W'(CNT_HEXB);
            end
            default: begin
              d_n   = nib2ascii(din[DATA_W-1 -: 4]);
              sh_n  = din << 4;
              nib_n = NIB_W'(1);
              grp_n = NIB_W'(1);
              rem_n = (mode_e'(mode) == MODE_HEXNL) ? CNT_W'(CNT_HEXNL) : CNT_W'(CNT_HEX);
            end
          endcase
        end
      end

      S_EMIT: begin
        if (vld_tx && rdy_tx) begin
          if (rem == CNT_W'(1)) begin
            vld_n   = 1'b0;
            rem_n   = '0;
            ack_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            rem_n = rem - CNT_W'(1);
            if (nib_done < nib_total) begin
              if (sep_ok && (int'(grp_cnt) == GROUP)) begin
                d_n   = SEP_CHAR;
                grp_n = '0;
              end else begin
                d_n   = nib2ascii(sh[DATA_W-1 -: 4]);
                sh_n  = sh << 4;
                nib_n = nib_done + NIB_W'(1);
                grp_n = grp_cnt + NIB_W'(1);
              end
            end else begin
              d_n = (rem == CNT_W'(3)) ? CR : LF;
            end
          end
        end
      end

      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_print_fmt.sv
// Bench for print_fmt: a grouped (GROUP=4) and an ungrouped (GROUP=0) instance
// share stimulus; a string-level model predicts each character stream.
module tb_print_fmt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic [1:0]  mode = '0;
  logic        req = 1'b0;
  logic        rdy_tx = 1'b1;

  logic [1:0]      vld_v, ack_v, busy_v;
  logic [1:0][7:0] d_v;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_mem [2][0:63];
  int         head [2] = '{0, 0};
  int         tail [2] = '{0, 0};
  int         xfer [2] = '{0, 0};
  logic       ack_exp [2] = '{1'b0, 1'b0};
  int         rdy_mode = 0;

  logic [7:0] seq [0:15];
  int         seq_len = 0;

  logic [7:0] lit_hex [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h5F, 8'h41, 8'h42, 8'h43, 8'h44};

  initial forever #5 clk = ~clk;

  print_fmt #(.DATA_W(32), .GROUP(4), .SEP_CHAR(8'h5F)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .req(req), .rdy_tx(rdy_tx),
    .vld_tx(vld_v[0]), .d_tx(d_v[0]), .ack(ack_v[0]), .busy(busy_v[0])
  );

  print_fmt #(.DATA_W(32), .GROUP(0), .SEP_CHAR(8'h5F)) dut_nogrp (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .req(req), .rdy_tx(rdy_tx),
    .vld_tx(vld_v[1]), .d_tx(d_v[1]), .ack(ack_v[1]), .busy(busy_v[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected character stream, built digit by digit from the printing rules.
  function automatic void gen(input logic [31:0] v, input logic [1:0] m, input int grp);
    int n;
    logic [3:0] nib;
    logic [31:0] src;
    seq_len = 0;
    if (m == 2'd0) begin
      seq[0]  = v[7:0];
      seq_len = 1;
      return;
    end
    n   = (m == 2'd3) ? 2 : 8;
    src = (m == 2'd3) ? {24'h0, v[7:0]} : v;
    for (int i = 1; i <= n; i++) begin
      nib = 4'((src >> (4 * (n - i))) & 32'hF);
      seq[seq_len] = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib) - 8'd10);
      seq_len++;
      if (m != 2'd3 && grp != 0 && (i % grp) == 0 && i < n) begin
        seq[seq_len] = 8'h5F;
        seq_len++;
      end
    end
    if (m == 2'd2) begin
      seq[seq_len]     = 8'h0D;
      seq[seq_len + 1] = 8'h0A;
      seq_len += 2;
    end
  endfunction

  task automatic pushModel(input int k, input logic [31:0] v, input logic [1:0] m);
    gen(v, m, (k == 0) ? 4 : 0);
    if (head[k] == tail[k]) begin
      head[k] = 0;
      tail[k] = 0;
    end
    for (int i = 0; i < seq_len; i++) begin
      exp_mem[k][tail[k]] = seq[i];
      tail[k]++;
    end
  endtask

  // Every cycle: vld/busy/ack follow the outstanding queue, d_tx its head.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic pend;
      logic ack_now;
      pend       = (head[k] < tail[k]);
      ack_now    = ack_exp[k];
      ack_exp[k] = 1'b0;
      checkOutput($sformatf("vld_tx[%0d]", k), 32'(vld_v[k]), 32'(pend));
      checkOutput($sformatf("busy[%0d]", k), 32'(busy_v[k]), 32'(pend | ack_now));
      checkOutput($sformatf("ack[%0d]", k), 32'(ack_v[k]), 32'(ack_now));
      if (rst) begin
        checkOutput($sformatf("d_tx_reset[%0d]", k), 32'(d_v[k]), 32'h0);
      end else if (pend) begin
        checkOutput($sformatf("d_tx[%0d] char %0d", k, head[k]), 32'(d_v[k]), 32'(exp_mem[k][head[k]]));
        if (rdy_tx) begin
          head[k]++;
          xfer[k]++;
          if (head[k] == tail[k]) ack_exp[k] = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       rdy_tx = 1'b1;
      1:       rdy_tx = ($urandom_range(0, 3) != 0);
      default: rdy_tx = 1'b0;
    endcase
  end

  task automatic waitIdle();
    int c = 0;
    while ((head[0] != tail[0] || head[1] != tail[1] || busy_v != 2'b00) && c < 500) begin
      @(posedge clk);
      c++;
    end
    checkOutput("idle_reached", 32'(c < 500), 32'd1);
    @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] v, input logic [1:0] m, input bit hold);
    waitIdle();
    #1;
    req  = 1'b0;
    din  = v;
    mode = m;
    @(posedge clk);
    #1;
    req = 1'b1;
    @(posedge clk);
    pushModel(0, v, m);
    pushModel(1, v, m);
    #1;
    din  = $urandom;
    mode = 2'($urandom_range(0, 3));
    if (!hold) req = 1'b0;
  endtask

  task automatic waitXfer(input int target);
    int c = 0;
    while (xfer[0] < target && c < 100) begin
      @(posedge clk);
      c++;
    end
    checkOutput("xfer_reached", 32'(xfer[0] >= target), 32'd1);
  endtask

  initial begin
    int base;

    gen(32'h1234ABCD, 2'd1, 4);
    checkOutput("model_len_hex", 32'(seq_len), 32'd9);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("model_hex_%0d", i), 32'(seq[i]), 32'(lit_hex[i]));
    gen(32'h0, 2'd2, 0);
    checkOutput("model_len_hexnl", 32'(seq_len), 32'd10);
    checkOutput("model_hexnl_0", 32'(seq[0]), 32'h30);
    checkOutput("model_hexnl_cr", 32'(seq[8]), 32'h0D);
    checkOutput("model_hexnl_lf", 32'(seq[9]), 32'h0A);
    gen(32'hFFFFFF5A, 2'd0, 4);
    checkOutput("model_len_raw", 32'(seq_len), 32'd1);
    checkOutput("model_raw", 32'(seq[0]), 32'h5A);
    gen(32'h0000000F, 2'd3, 4);
    checkOutput("model_len_hexb", 32'(seq_len), 32'd2);
    checkOutput("model_hexb_0", 32'(seq[0]), 32'h30);
    checkOutput("model_hexb_1", 32'(seq[1]), 32'h46);

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    $display("[TB] directed prints");
    applyStimulus(32'h1234ABCD, 2'd1, 1'b0);
    applyStimulus(32'hFFFFFF5A, 2'd0, 1'b0);
    applyStimulus(32'h0000000F, 2'd3, 1'b0);
    applyStimulus(32'h00000000, 2'd2, 1'b0);

    $display("[TB] backpressure on third char");
    waitIdle();
    base = xfer[0];
    applyStimulus(32'h1234ABCD, 2'd1, 1'b0);
    waitXfer(base + 2);
    rdy_mode = 2;
    repeat (5) @(posedge clk);
    rdy_mode = 0;

    $display("[TB] held req with mid-print edge");
    applyStimulus(32'hDEADBEEF, 2'd1, 1'b1);
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 req = 1'b1;
    din = 32'h55555555;
    repeat (35) @(posedge clk);
    #1 req = 1'b0;

    $display("[TB] reset mid-stream");
    waitIdle();
    base = xfer[0];
    applyStimulus(32'h1234ABCD, 2'd2, 1'b0);
    waitXfer(base + 4);
    #3;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      head[k]    = 0;
      tail[k]    = 0;
      ack_exp[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    applyStimulus(32'h1234ABCD, 2'd1, 1'b0);

    $display("[TB] random prints");
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) applyStimulus($urandom, 2'($urandom_range(0, 3)), 1'b0);
    waitIdle();
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/print_fmt.md
Name: print_fmt

Overview:
Parametrised print formatter for the serial debug unit. It converts one captured data value into an ASCII character stream for the UART transmitter. Output modes are raw byte, hex byte, grouped hex word, and grouped hex word with CR/LF. Hex digits are generated arithmetically, with no lookup memory. The block sits between the command/debug controller (req/ack side) and the UART TX (vld_tx/rdy_tx side).

Parameters:
DATA_W, 32, data width in bits; multiple of 8, range 8..64.
GROUP, 4, hex nibbles between separators; 0 means no separators.
SEP_CHAR, 8'h5F, separator character ('_').

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
din  in  DATA_W  value to print; sampled only at request start
mode  in  2  0 raw byte (din[7:0]); 1 hex word; 2 hex word + CR LF; 3 hex byte (din[7:0] as 2 digits)
req  in  1  print request; level input, rising edge starts a print
rdy_tx  in  1  UART TX ready to accept a character
vld_tx  out  1  d_tx holds a valid character
d_tx  out  8  ASCII character
ack  out  1  one-cycle pulse when the last character has been accepted
busy  out  1  high from request start until ack

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset: vld_tx=0, d_tx=8'h00, ack=0, busy=0, state=IDLE, edge register=0, counters=0.
- Edge detect: req_q <= req; start = req & ~req_q & (state==IDLE). A req held high produces exactly one print. Edges while busy are ignored and not queued.
- Character transfer occurs in any cycle where vld_tx && rdy_tx. While vld_tx=1 and rdy_tx=0, d_tx is held stable.
- States:
  - IDLE: on start, latch din into a shift register, latch mode, load the character count, go to EMIT. Set vld_tx=1, d_tx=first char, busy=1 in the same clock edge. vld_tx therefore rises 1 cycle after the cycle in which start is true.
  - EMIT: on transfer of a non-last char, present the next char on the next cycle with vld_tx held at 1 (back-to-back, no bubble). On transfer of the last char, vld_tx<=0 and go to DONE.
  - DONE: ack=1 for exactly one cycle, busy<=0, go to IDLE. An edge seen in DONE is ignored.
- Sequence per mode (N = DATA_W/4 for modes 1/2; N = 2 for mode 3):
  - Mode 0: 1 char, din[7:0] verbatim.
  - Modes 1/2: nibbles MSB first. After nibble i (1-based), emit SEP_CHAR if GROUP!=0, i%GROUP==0 and i<N. No trailing or leading separator.
  - Mode 2: append 8'h0D then 8'h0A.
  - Mode 3: 2 nibbles of din[7:0]; no separator.
- Char count = N + (GROUP ? (N-1)/GROUP : 0) + (mode==2 ? 2 : 0); mode 0 count = 1. Counter width is clog2(max count + 1).
- Hex mapping, uppercase: n<10 -> 8'h30+n; n>=10 -> 8'h37+n.
- din and mode changes after start have no effect on the print in progress.
- Reset mid-stream aborts immediately: outputs return to reset values, no ack, no further chars.

Decomposition:
- Package print_fmt_pkg:
  - mode encodings MODE_RAW=0, MODE_HEX=1, MODE_HEXNL=2, MODE_HEXB=3;
  - ASCII constants CR=8'h0D, LF=8'h0A;
  - function nib2ascii(4-bit) -> 8-bit;
  - function char_count(mode, DATA_W, GROUP).
- Sub-module req_edge_det: async-reset rising-edge detector (1 register plus AND). It is reusable by the other debug-unit blocks.

Test Plan:
1. DATA_W=32, GROUP=4, mode=1, din=32'h1234ABCD, rdy_tx=1 -> d_tx 31 32 33 34 5F 41 42 43 44 on 9 consecutive cycles; ack pulse 1 cycle after the 44 transfer; busy low afterwards.
2. mode=0, din=32'hFFFFFF5A -> single char 5A, then ack; mode=3, din=32'h0000000F -> 30 46, then ack.
3. mode=2, din=32'h00000000, GROUP=0 (separate elaboration) -> 30 x8, 0D, 0A; 10 transfers then ack.
4. Backpressure: mode=1, rdy_tx held low 5 cycles while the 3rd char (33) is presented -> d_tx=33 and vld_tx=1 stable throughout; no char skipped or duplicated.
5. req held high for 40 cycles, plus a second rising edge issued mid-print -> exactly one 9-char print and one ack; din changed mid-print does not alter output.
6. rst asserted asynchronously after the 4th transfer -> vld_tx=0, busy=0, ack never pulses; a fresh req edge after release prints the full sequence from the first char.
